// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared definitions for the machine-mode trap controller:
//                CSR addresses, mstatus/mip bit positions, cause codes,
//                FSM state encoding and the interrupt priority helper.
//  Revision    : 1.0  initial release
// ============================================================================
package trap_pkg;

  // CSR address map
  localparam logic [11:0] c_csr_mstatus  = 12'h300;
  localparam logic [11:0] c_csr_mie      = 12'h304;
  localparam logic [11:0] c_csr_mtvec    = 12'h305;
  localparam logic [11:0] c_csr_mscratch = 12'h340;
  localparam logic [11:0] c_csr_mepc     = 12'h341;
  localparam logic [11:0] c_csr_mcause   = 12'h342;
  localparam logic [11:0] c_csr_mtval    = 12'h343;
  localparam logic [11:0] c_csr_mip      = 12'h344;

  // mstatus bit positions
  localparam int c_mstatus_mie    = 3;
  localparam int c_mstatus_mpie   = 7;
  localparam int c_mstatus_mpp_lo = 11;
  localparam int c_mstatus_mpp_hi = 12;

  // mip/mie bit positions
  localparam int c_irq_sw_bit    = 3;
  localparam int c_irq_timer_bit = 7;
  localparam int c_irq_ext_bit   = 11;

  // Cause codes
  localparam logic [4:0] c_cause_irq_sw    = 5'd3;
  localparam logic [4:0] c_cause_irq_timer = 5'd7;
  localparam logic [4:0] c_cause_irq_ext   = 5'd11;
  localparam logic [4:0] c_cause_ecall_m   = 5'd11;

  // Trap sequencer state
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  // Kind of event captured when the sequencer leaves IDLE
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_IRQ  = 2'd2,
    EV_MRET = 2'd3
  } trap_event_e;

  // Interrupt priority: external > software > timer.
  // Caller guarantees at least one input is set.
  function automatic logic [4:0] irq_cause(input logic ext, input logic sw);
    if (ext)     return c_cause_irq_ext;
    else if (sw) return c_cause_irq_sw;
    else         return c_cause_irq_timer;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_if
//  Description : Core-side bundle of the trap controller: exception/interrupt
//                event inputs, CSR access bus and pipeline control outputs.
//                master = pipeline side, slave = trap_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            exception_i;
  logic [4:0]      exception_code_i;
  logic [XLEN-1:0] exc_tval_i;
  logic            wb_valid_i;
  logic [XLEN-1:0] wb_pc_i;
  logic            mret_i;
  logic            irq_ext_i;
  logic            irq_sw_i;
  logic            irq_timer_i;
  logic            csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            flush_o;
  logic            stall_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output exception_i, exception_code_i, exc_tval_i, wb_valid_i, wb_pc_i,
           mret_i, irq_ext_i, irq_sw_i, irq_timer_i,
           csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, flush_o, stall_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  exception_i, exception_code_i, exc_tval_i, wb_valid_i, wb_pc_i,
           mret_i, irq_ext_i, irq_sw_i, irq_timer_i,
           csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, flush_o, stall_o, redirect_o, redirect_pc_o
  );
endinterface
`default_nettype wire

// File: rtl/trap_csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : trap_csr_file
//  Description : Machine-mode trap CSRs (mstatus, mie, mip, mtvec, mscratch,
//                mepc, mcause, mtval): storage, write decode, read mux.
//                Hardware trap/mret updates take precedence over software
//                writes for mstatus/mepc/mcause/mtval.
//  Config      : TRAP_VECTORED_EN - mtvec[0] (mode) writable
//  Ports       : clk/reset, i_we/i_addr/i_wdata/o_rdata CSR bus,
//                i_trap_take/i_mret_take + cause/epc/tval hardware update,
//                i_irq_* interrupt lines, o_* state for the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            i_we,
  input  wire logic [11:0]     i_addr,
  input  wire logic [XLEN-1:0] i_wdata,
  output logic      [XLEN-1:0] o_rdata,
  input  wire logic            i_trap_take,
  input  wire logic            i_mret_take,
  input  wire logic [XLEN-1:0] i_cause,
  input  wire logic [XLEN-1:0] i_epc,
  input  wire logic [XLEN-1:0] i_tval,
  input  wire logic            i_irq_ext,
  input  wire logic            i_irq_sw,
  input  wire logic            i_irq_timer,
  output logic                 o_mstatus_mie,
  output logic      [XLEN-1:0] o_mie,
  output logic      [XLEN-1:0] o_mip,
  output logic      [XLEN-1:0] o_mtvec,
  output logic      [XLEN-1:0] o_mepc
);

  // Only the three implemented interrupt enables are writable
  localparam logic [XLEN-1:0] c_irq_mask =
      (XLEN'(1) << c_irq_sw_bit) | (XLEN'(1) << c_irq_timer_bit) | (XLEN'(1) << c_irq_ext_bit);

`ifdef TRAP_VECTORED_EN
  localparam logic [XLEN-1:0] c_mtvec_mask = ~(XLEN'(2));
`else
  localparam logic [XLEN-1:0] c_mtvec_mask = ~(XLEN'(3));
`endif

  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_mstatus;

  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
  logic w_wr_mepc, w_wr_mcause, w_wr_mtval;

  assign w_wr_mstatus  = i_we && (i_addr == c_csr_mstatus);
  assign w_wr_mie      = i_we && (i_addr == c_csr_mie);
  assign w_wr_mtvec    = i_we && (i_addr == c_csr_mtvec);
  assign w_wr_mscratch = i_we && (i_addr == c_csr_mscratch);
  assign w_wr_mepc     = i_we && (i_addr == c_csr_mepc);
  assign w_wr_mcause   = i_we && (i_addr == c_csr_mcause);
  assign w_wr_mtval    = i_we && (i_addr == c_csr_mtval);

  // mstatus: trap entry stacks MIE into MPIE, mret unstacks it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (i_trap_take) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (i_mret_take) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mstatus_mie  <= i_wdata[c_mstatus_mie];
      r_mstatus_mpie <= i_wdata[c_mstatus_mpie];
    end
  end

  // Software-only CSRs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mie      <= '0;
      r_mtvec    <= RESET_MTVEC & c_mtvec_mask;
      r_mscratch <= '0;
    end else begin
      if (w_wr_mie)      r_mie      <= i_wdata & c_irq_mask;
      if (w_wr_mtvec)    r_mtvec    <= i_wdata & c_mtvec_mask;
      if (w_wr_mscratch) r_mscratch <= i_wdata;
    end
  end

  // Trap-state CSRs: hardware entry beats a coincident software write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (i_trap_take) begin
      r_mepc   <= {i_epc[XLEN-1:2], 2'b00};
      r_mcause <= i_cause;
      r_mtval  <= i_tval;
    end else begin
      if (w_wr_mepc)   r_mepc   <= {i_wdata[XLEN-1:2], 2'b00};
      if (w_wr_mcause) r_mcause <= i_wdata;
      if (w_wr_mtval)  r_mtval  <= i_wdata;
    end
  end

  always_comb begin
    w_mip                  = '0;
    w_mip[c_irq_sw_bit]    = i_irq_sw;
    w_mip[c_irq_timer_bit] = i_irq_timer;
    w_mip[c_irq_ext_bit]   = i_irq_ext;
  end

  // MPP is hardwired to machine mode
  always_comb begin
    w_mstatus                                     = '0;
    w_mstatus[c_mstatus_mie]                      = r_mstatus_mie;
    w_mstatus[c_mstatus_mpie]                     = r_mstatus_mpie;
    w_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo]  = 2'b11;
  end

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      c_csr_mstatus:  o_rdata = w_mstatus;
      c_csr_mie:      o_rdata = r_mie;
      c_csr_mtvec:    o_rdata = r_mtvec;
      c_csr_mscratch: o_rdata = r_mscratch;
      c_csr_mepc:     o_rdata = r_mepc;
      c_csr_mcause:   o_rdata = r_mcause;
      c_csr_mtval:    o_rdata = r_mtval;
      c_csr_mip:      o_rdata = w_mip;
      default:        o_rdata = '0;
    endcase
  end

  assign o_mstatus_mie = r_mstatus_mie;
  assign o_mie         = r_mie;
  assign o_mip         = w_mip;
  assign o_mtvec       = r_mtvec;
  assign o_mepc        = r_mepc;

  // Low epc bits are discarded on purpose (alignment)
  logic w_unused_epc;
  assign w_unused_epc = ^i_epc[1:0];

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Machine-mode trap controller. Arbitrates exception >
//                interrupt > mret at the WB boundary, updates trap CSRs and
//                sequences IDLE -> FLUSH -> REDIRECT -> IDLE towards fetch.
//  Config      : TRAP_VECTORED_EN - vectored interrupt targets
//                (base + 4*cause) when mtvec[0] = 1
//  Ports       : clk, reset (sync, active-high),
//                bus (trap_ctrl_if.slave): events, CSR bus, flush/stall/redirect
//  Revision    : 1.0  initial release
// ============================================================================
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  wire logic  clk,
  input  wire logic  reset,
  trap_ctrl_if.slave bus
);

  trap_state_e r_state;
  trap_state_e w_state_nxt;
  trap_event_e r_event;
  logic [4:0]      r_irq_code;
  logic [XLEN-1:0] r_target;

  logic            w_mstatus_mie;
  logic [XLEN-1:0] w_mie;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_mtvec;
  logic [XLEN-1:0] w_mepc;
  logic [XLEN-1:0] w_pend;
  logic            w_idle;
  logic            w_irq_req;
  logic            w_take_exc;
  logic            w_take_irq;
  logic            w_take_mret;
  logic [4:0]      w_irq_code;
  logic [XLEN-1:0] w_hw_cause;
  logic [XLEN-1:0] w_hw_tval;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_pend    = w_mip & w_mie;
  assign w_irq_req = bus.wb_valid_i && w_mstatus_mie && (|w_pend);

  // Priority: exception > interrupt > mret. A losing IRQ simply stays pending.
  assign w_take_exc  = w_idle && bus.exception_i;
  assign w_take_irq  = w_idle && !bus.exception_i && w_irq_req;
  assign w_take_mret = w_idle && !bus.exception_i && !w_irq_req && bus.mret_i;

  assign w_irq_code = irq_cause(w_pend[c_irq_ext_bit], w_pend[c_irq_sw_bit]);

  assign w_hw_cause = w_take_exc ? {{(XLEN-5){1'b0}}, bus.exception_code_i}
                                 : {1'b1, {(XLEN-6){1'b0}}, w_irq_code};

  // ecall carries no faulting value; interrupts never do
  assign w_hw_tval = (w_take_exc && (bus.exception_code_i != c_cause_ecall_m))
                     ? bus.exc_tval_i : '0;

  trap_csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk           (clk),
    .reset         (reset),
    .i_we          (bus.csr_we_i && w_idle),
    .i_addr        (bus.csr_addr_i),
    .i_wdata       (bus.csr_wdata_i),
    .o_rdata       (bus.csr_rdata_o),
    .i_trap_take   (w_take_exc || w_take_irq),
    .i_mret_take   (w_take_mret),
    .i_cause       (w_hw_cause),
    .i_epc         (bus.wb_pc_i),
    .i_tval        (w_hw_tval),
    .i_irq_ext     (bus.irq_ext_i),
    .i_irq_sw      (bus.irq_sw_i),
    .i_irq_timer   (bus.irq_timer_i),
    .o_mstatus_mie (w_mstatus_mie),
    .o_mie         (w_mie),
    .o_mip         (w_mip),
    .o_mtvec       (w_mtvec),
    .o_mepc        (w_mepc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_take_exc || w_take_irq || w_take_mret) w_state_nxt = ST_FLUSH;
      ST_FLUSH:    w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.flush_o       = 1'b0;
    bus.stall_o       = 1'b0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    case (r_state)
      ST_FLUSH: begin
        bus.flush_o = 1'b1;
        bus.stall_o = 1'b1;
      end
      ST_REDIRECT: begin
        bus.stall_o       = 1'b1;
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = r_target;
      end
      default: ;
    endcase
  end

  // Remember what was accepted so FLUSH can compute the target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_event    <= EV_NONE;
      r_irq_code <= '0;
    end else if (w_idle) begin
      r_irq_code <= w_irq_code;
      if (w_take_exc)       r_event <= EV_EXC;
      else if (w_take_irq)  r_event <= EV_IRQ;
      else if (w_take_mret) r_event <= EV_MRET;
    end
  end

  assign w_base = {w_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    w_target = w_base;
    if (r_event == EV_MRET) begin
      w_target = w_mepc;
    end
`ifdef TRAP_VECTORED_EN
    else if ((r_event == EV_IRQ) && w_mtvec[0]) begin
      w_target = w_base + {{(XLEN-7){1'b0}}, r_irq_code, 2'b00};
    end
`endif
  end

  // Target is latched during FLUSH; CSR writes are blocked there so it is stable
  always_ff @(posedge clk) begin
    if (reset)                   r_target <= '0;
    else if (r_state == ST_FLUSH) r_target <= w_target;
  end

  // mtvec mode bits only matter in the vectored build
  logic w_unused_mtvec;
  assign w_unused_mtvec = ^w_mtvec[1:0];

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Self-checking bench for trap_ctrl. Expected redirect targets
//                are queued when an event is driven and popped when the DUT
//                raises redirect_o; CSR state is checked after each event.
//  Config      : TRAP_VECTORED_EN selects vectored expectations
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;
  import trap_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];

  trap_ctrl_if #(.XLEN(32)) bus();

  trap_ctrl #(
    .XLEN        (32),
    .RESET_MTVEC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard: every redirect must match the oldest queued target
  always @(negedge clk) begin
    if (bus.redirect_o === 1'b1) begin
      if (exp_q.size() == 0) check_eq("redir_unexpected", {31'b0, bus.redirect_o}, 32'd0);
      else                   check_eq("redirect_pc", bus.redirect_pc_o, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = d;
    @(posedge clk); #1;
    bus.csr_we_i    = 1'b0;
  endtask

  task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr_i = a;
    @(negedge clk);
    check_eq(tag, bus.csr_rdata_o, exp);
  endtask

  // Drive one event for a single cycle and check the flush/redirect timeline
  task automatic fire(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                      input logic [31:0] tval, input logic wbv, input logic mret,
                      input logic [31:0] exp_pc);
    exp_q.push_back(exp_pc);
    bus.exception_i      = exc;
    bus.exception_code_i = code;
    bus.wb_pc_i          = pc;
    bus.exc_tval_i       = tval;
    bus.wb_valid_i       = wbv;
    bus.mret_i           = mret;
    @(posedge clk); #1;
    bus.exception_i = 1'b0;
    bus.wb_valid_i  = 1'b0;
    bus.mret_i      = 1'b0;
    @(negedge clk);
    check_eq("flush_n1",  {31'b0, bus.flush_o},    32'd1);
    check_eq("stall_n1",  {31'b0, bus.stall_o},    32'd1);
    check_eq("redir_n1",  {31'b0, bus.redirect_o}, 32'd0);
    @(negedge clk);
    check_eq("redir_n2",  {31'b0, bus.redirect_o}, 32'd1);
    check_eq("flush_n2",  {31'b0, bus.flush_o},    32'd0);
    @(negedge clk);
    check_eq("stall_idle", {31'b0, bus.stall_o},   32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.exception_i = 1'b0; bus.exception_code_i = '0; bus.exc_tval_i = '0;
    bus.wb_valid_i = 1'b0;  bus.wb_pc_i = '0;          bus.mret_i = 1'b0;
    bus.irq_ext_i = 1'b0;   bus.irq_sw_i = 1'b0;       bus.irq_timer_i = 1'b0;
    bus.csr_we_i = 1'b0;    bus.csr_addr_i = '0;       bus.csr_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_flush", {31'b0, bus.flush_o},    32'd0);
    check_eq("rst_redir", {31'b0, bus.redirect_o}, 32'd0);
    check_eq("rst_stall", {31'b0, bus.stall_o},    32'd0);
    csr_chk("rst_mstatus", c_csr_mstatus, 32'h0000_1800);
    csr_chk("rst_mtvec",   c_csr_mtvec,   32'h0);

    // 1: synchronous exception
    csr_wr(c_csr_mtvec, 32'h100);
    fire(1'b1, 5'd2, 32'h40, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h100);
    csr_chk("t1_mepc",   c_csr_mepc,   32'h40);
    csr_chk("t1_mcause", c_csr_mcause, 32'h2);
    csr_chk("t1_mtval",  c_csr_mtval,  32'hFFFF_FFFF);

    // 2: timer interrupt
    csr_wr(c_csr_mstatus, 32'h8);
    csr_wr(c_csr_mie, 32'h80);
    bus.irq_timer_i = 1'b1;
    fire(1'b0, 5'd0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h100);
    bus.irq_timer_i = 1'b0;
    csr_chk("t2_mcause",  c_csr_mcause,  32'h8000_0007);
    csr_chk("t2_mepc",    c_csr_mepc,    32'h80);
    csr_chk("t2_mtval",   c_csr_mtval,   32'h0);
    csr_chk("t2_mstatus", c_csr_mstatus, 32'h0000_1880);

    // 3: mret back to interrupted PC
    fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80);
    csr_chk("t3_mstatus", c_csr_mstatus, 32'h0000_1888);

    // 4: exception beats a simultaneous external IRQ, IRQ taken after mret
    csr_wr(c_csr_mie, 32'h800);
    bus.irq_ext_i = 1'b1;
    fire(1'b1, 5'd4, 32'h44, 32'h1234, 1'b1, 1'b0, 32'h100);
    csr_chk("t4_mcause",  c_csr_mcause,  32'h4);
    csr_chk("t4_mtval",   c_csr_mtval,   32'h1234);
    csr_chk("t4_mstatus", c_csr_mstatus, 32'h0000_1880);
    csr_chk("t4_mip",     c_csr_mip,     32'h800);
    fire(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44);
    fire(1'b0, 5'd0, 32'h48, 32'h0, 1'b1, 1'b0, 32'h100);
    bus.irq_ext_i = 1'b0;
    csr_chk("t4_mcause2", c_csr_mcause, 32'h8000_000B);
    csr_chk("t4_mepc2",   c_csr_mepc,   32'h48);

    // ecall: tval forced to 0, epc aligned
    fire(1'b1, 5'd11, 32'h4E, 32'hDEAD, 1'b1, 1'b0, 32'h100);
    csr_chk("ecall_mtval",  c_csr_mtval,  32'h0);
    csr_chk("ecall_mepc",   c_csr_mepc,   32'h4C);
    csr_chk("ecall_mcause", c_csr_mcause, 32'hB);

    // CSR corner cases
    csr_wr(12'h7C0, 32'hFFFF);
    csr_chk("unmapped", 12'h7C0, 32'h0);
    csr_wr(c_csr_mepc, 32'h103);
    csr_chk("mepc_align", c_csr_mepc, 32'h100);
    csr_wr(c_csr_mscratch, 32'hCAFE_BABE);
    csr_chk("mscratch", c_csr_mscratch, 32'hCAFE_BABE);

    // 5: reset during FLUSH aborts the redirect
    @(posedge clk); #1;
    bus.exception_i = 1'b1; bus.exception_code_i = 5'd2; bus.wb_pc_i = 32'h60;
    bus.exc_tval_i = 32'h77; bus.wb_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.exception_i = 1'b0; bus.wb_valid_i = 1'b0;
    @(negedge clk);
    check_eq("t5_flush", {31'b0, bus.flush_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_redir",  {31'b0, bus.redirect_o}, 32'd0);
    check_eq("t5_stall",  {31'b0, bus.stall_o},    32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("t5_redir2", {31'b0, bus.redirect_o}, 32'd0);
    csr_chk("t5_mtvec",    c_csr_mtvec,    32'h0);
    csr_chk("t5_mepc",     c_csr_mepc,     32'h0);
    csr_chk("t5_mcause",   c_csr_mcause,   32'h0);
    csr_chk("t5_mtval",    c_csr_mtval,    32'h0);
    csr_chk("t5_mscratch", c_csr_mscratch, 32'h0);
    csr_chk("t5_mie",      c_csr_mie,      32'h0);
    csr_chk("t5_mstatus",  c_csr_mstatus,  32'h0000_1800);

    // 6: mtvec mode bit and vectored software interrupt
    @(posedge clk); #1;
    csr_wr(c_csr_mtvec, 32'h201);
`ifdef TRAP_VECTORED_EN
    csr_chk("t6_mtvec", c_csr_mtvec, 32'h201);
`else
    csr_chk("t6_mtvec", c_csr_mtvec, 32'h200);
`endif
    csr_wr(c_csr_mstatus, 32'h8);
    csr_wr(c_csr_mie, 32'h8);
    bus.irq_sw_i = 1'b1;
`ifdef TRAP_VECTORED_EN
    fire(1'b0, 5'd0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h20C);
`else
    fire(1'b0, 5'd0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h200);
`endif
    bus.irq_sw_i = 1'b0;
    csr_chk("t6_mcause", c_csr_mcause, 32'h8000_0003);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
